maf_t3_align_reg: RTL and testbench

//  T3 stage of the multi-precision MAF pipeline, directly downstream of the T2 exponent-select register.
//  - Right-aligns the addend (C) mantissa by the T2 shift amount(s).
//  - Forms per-lane effective-subtract and sticky bits.
//  - Registers the result together with the pass-through product, signs, mode and exponent.

---
 rtl/maf_t3_align_reg.sv | 164 ++++++++++++++++
 tb/tb_maf_t3_align_reg.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/maf_t3_align_reg.sv
// T3 stage of the multi-precision MAF pipeline: aligns the addend mantissa per lane,
// forms effective-subtract/sticky bits and registers everything behind a valid/ready handshake.
module maf_t3_align_reg #(
    parameter int PW = 576,
    parameter int AW = 162,
    parameter int EW = 12
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    cont_T2,
    input  logic          S_A_T2,
    input  logic          S_B_T2,
    input  logic          S_C_T2,
    input  logic          S_A_H_T2,
    input  logic          S_B_H_T2,
    input  logic          S_C_H_T2,
    input  logic [EW-1:0] d_T2,
    input  logic [EW-1:0] E_T2,
    input  logic [52:0]   mant_c,
    input  logic [PW-1:0] M_in,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [AW-1:0] c_aligned,
    output logic [1:0]    sticky,
    output logic [1:0]    eff_sub,
    output logic [1:0]    inc_req,
    output logic          mode_err,
    output logic [2:0]    cont_T3,
    output logic [EW-1:0] E_T3,
    output logic [PW-1:0] M_out
);

    localparam int LW = AW / 2;

    // Returns {sticky, window}: mantissa placed at the top of the window and shifted right,
    // with everything that falls below bit 0 ORed into sticky. Shifts >= width empty the window.
    function automatic logic [AW:0] alignFull(input logic [52:0] mant, input logic [EW-1:0] sh);
        logic [2*AW-1:0] ext;
        logic [AW:0]     res;
        if (sh >= EW'(AW)) begin
            res = {|mant, {AW{1'b0}}};
        end else begin
            ext = {mant, {(2*AW-53){1'b0}}} >> sh;
            res = {|ext[AW-1:0], ext[2*AW-1:AW]};
        end
        return res;
    endfunction

    function automatic logic [LW:0] alignLane(input logic [23:0] mant, input logic [EW-1:0] sh);
        logic [2*LW-1:0] ext;
        logic [LW:0]     res;
        if (sh >= EW'(LW)) begin
            res = {|mant, {LW{1'b0}}};
        end else begin
            ext = {mant, {(2*LW-24){1'b0}}} >> sh;
            res = {|ext[LW-1:0], ext[2*LW-1:LW]};
        end
        return res;
    endfunction

    logic [AW:0] fp64Res;
    logic [LW:0] dualHiRes;
    logic [LW:0] dualLoRes;
    logic [LW:0] singleRes;
    logic        effLo;
    logic        effHi;

    assign effLo     = S_A_T2 ^ S_B_T2 ^ S_C_T2;
    assign effHi     = S_A_H_T2 ^ S_B_H_T2 ^ S_C_H_T2;
    assign fp64Res   = alignFull(mant_c, d_T2);
    assign dualHiRes = alignLane(mant_c[47:24], {{(EW-6){1'b0}}, d_T2[11:6]});
    assign dualLoRes = alignLane(mant_c[23:0],  {{(EW-6){1'b0}}, d_T2[5:0]});
    assign singleRes = alignLane(mant_c[23:0], d_T2);

    logic [AW-1:0] c_aligned_d;
    logic [1:0]    sticky_d;
    logic [1:0]    eff_sub_d;
    logic          mode_err_d;

    // Mode select; inversion applies after shifting, sticky is taken from the uninverted value.
    always_comb begin
        c_aligned_d = '0;
        sticky_d    = 2'b00;
        eff_sub_d   = 2'b00;
        mode_err_d  = 1'b0;
        case (cont_T2)
            3'b000: begin
                c_aligned_d = effLo ? ~fp64Res[AW-1:0] : fp64Res[AW-1:0];
                sticky_d    = {1'b0, fp64Res[AW]};
                eff_sub_d   = {1'b0, effLo};
            end
            3'b001: begin
                c_aligned_d[AW-1:LW] = effHi ? ~dualHiRes[LW-1:0] : dualHiRes[LW-1:0];
                c_aligned_d[LW-1:0]  = effLo ? ~dualLoRes[LW-1:0] : dualLoRes[LW-1:0];
                sticky_d             = {dualHiRes[LW], dualLoRes[LW]};
                eff_sub_d            = {effHi, effLo};
            end
            3'b010: begin
                c_aligned_d[LW-1:0] = effLo ? ~singleRes[LW-1:0] : singleRes[LW-1:0];
                sticky_d            = {1'b0, singleRes[LW]};
                eff_sub_d           = {1'b0, effLo};
            end
            default: begin
                mode_err_d = 1'b1;
            end
        endcase
    end

    logic          out_valid_q;
    logic [AW-1:0] c_aligned_q;
    logic [1:0]    sticky_q;
    logic [1:0]    eff_sub_q;
    logic [1:0]    inc_req_q;
    logic          mode_err_q;
    logic [2:0]    cont_q;
    logic [EW-1:0] exp_q;
    logic [PW-1:0] m_q;
    logic          capture;

    assign in_ready = ~out_valid_q | out_ready;
    assign capture  = in_valid & in_ready;

    // Data only moves on capture, so a stalled item holds until the downstream takes it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            c_aligned_q <= '0;
            sticky_q    <= 2'b00;
            eff_sub_q   <= 2'b00;
            inc_req_q   <= 2'b00;
            mode_err_q  <= 1'b0;
            cont_q      <= 3'b000;
            exp_q       <= '0;
            m_q         <= '0;
        end else begin
            if (capture) begin
                out_valid_q <= 1'b1;
                c_aligned_q <= c_aligned_d;
                sticky_q    <= sticky_d;
                eff_sub_q   <= eff_sub_d;
                inc_req_q   <= eff_sub_d & ~sticky_d;
                mode_err_q  <= mode_err_d;
                cont_q      <= cont_T2;
                exp_q       <= E_T2;
                m_q         <= M_in;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign c_aligned = c_aligned_q;
    assign sticky    = sticky_q;
    assign eff_sub   = eff_sub_q;
    assign inc_req   = inc_req_q;
    assign mode_err  = mode_err_q;
    assign cont_T3   = cont_q;
    assign E_T3      = exp_q;
    assign M_out     = m_q;

endmodule

// File: tb/tb_maf_t3_align_reg.sv
// Directed self-checking bench for maf_t3_align_reg: alignment per mode, saturation,
// invalid mode, back-pressure, back-to-back flow and asynchronous reset.
module tb_maf_t3_align_reg;

    localparam int PW = 576;
    localparam int AW = 162;
    localparam int EW = 12;

    logic          clk;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    cont_T2;
    logic          S_A_T2, S_B_T2, S_C_T2;
    logic          S_A_H_T2, S_B_H_T2, S_C_H_T2;
    logic [EW-1:0] d_T2;
    logic [EW-1:0] E_T2;
    logic [52:0]   mant_c;
    logic [PW-1:0] M_in;
    logic          out_ready;
    logic          out_valid;
    logic [AW-1:0] c_aligned;
    logic [1:0]    sticky;
    logic [1:0]    eff_sub;
    logic [1:0]    inc_req;
    logic          mode_err;
    logic [2:0]    cont_T3;
    logic [EW-1:0] E_T3;
    logic [PW-1:0] M_out;

    int checks = 0;
    int errors = 0;

    maf_t3_align_reg #(.PW(PW), .AW(AW), .EW(EW)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .cont_T2(cont_T2), .S_A_T2(S_A_T2), .S_B_T2(S_B_T2), .S_C_T2(S_C_T2),
        .S_A_H_T2(S_A_H_T2), .S_B_H_T2(S_B_H_T2), .S_C_H_T2(S_C_H_T2),
        .d_T2(d_T2), .E_T2(E_T2), .mant_c(mant_c), .M_in(M_in),
        .out_ready(out_ready), .out_valid(out_valid), .c_aligned(c_aligned),
        .sticky(sticky), .eff_sub(eff_sub), .inc_req(inc_req), .mode_err(mode_err),
        .cont_T3(cont_T3), .E_T3(E_T3), .M_out(M_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic driveItem(input logic [2:0] cont, input logic [5:0] signs,
                             input logic [EW-1:0] d, input logic [EW-1:0] e,
                             input logic [52:0] mant, input logic [PW-1:0] m);
        in_valid = 1'b1;
        cont_T2  = cont;
        {S_A_H_T2, S_B_H_T2, S_C_H_T2, S_A_T2, S_B_T2, S_C_T2} = signs;
        d_T2     = d;
        E_T2     = e;
        mant_c   = mant;
        M_in     = m;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset in_ready: got %b want 1", in_ready); end
        checks++; if (c_aligned !== '0) begin errors++; $display("[TB] FAIL reset c_aligned: got %h want 0", c_aligned); end
        checks++; if (M_out !== '0 || E_T3 !== '0 || cont_T3 !== 3'b0) begin errors++; $display("[TB] FAIL reset passthru: E_T3 %h cont_T3 %b want 0", E_T3, cont_T3); end
        checks++; if ({sticky, eff_sub, inc_req, mode_err} !== 7'b0) begin errors++; $display("[TB] FAIL reset flags: got %b want 0", {sticky, eff_sub, inc_req, mode_err}); end
    endtask

    task automatic test_fp64();
        logic [AW-1:0] exp;
        logic [PW-1:0] m;
        m = {18{32'hDEADBEEF}};
        // Full mantissa, shift 10, no subtraction
        driveItem(3'b000, 6'b000000, 12'd10, 12'h3FF, 53'h1F_FFFF_FFFF_FFFF, m);
        @(posedge clk); #1;
        exp = '0; exp[151:99] = '1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL fp64_d10 out_valid: got %b want 1", out_valid); end
        checks++; if (c_aligned !== exp) begin errors++; $display("[TB] FAIL fp64_d10 c_aligned: got %h want %h", c_aligned, exp); end
        checks++; if ({sticky, eff_sub, inc_req} !== 6'b0) begin errors++; $display("[TB] FAIL fp64_d10 flags: got %b want 000000", {sticky, eff_sub, inc_req}); end
        checks++; if (E_T3 !== 12'h3FF || M_out !== m || cont_T3 !== 3'b000) begin errors++; $display("[TB] FAIL fp64_d10 passthru: E_T3 %h cont_T3 %b", E_T3, cont_T3); end
        // Zero shift with effective subtract: whole window inverted
        driveItem(3'b000, 6'b000100, 12'd0, 12'h001, 53'h10_0000_0000_0001, m);
        @(posedge clk); #1;
        exp = '0; exp[161] = 1'b1; exp[109] = 1'b1; exp = ~exp;
        checks++; if (c_aligned !== exp) begin errors++; $display("[TB] FAIL fp64_sub c_aligned: got %h want %h", c_aligned, exp); end
        checks++; if ({sticky, eff_sub, inc_req} !== 6'b00_01_01) begin errors++; $display("[TB] FAIL fp64_sub flags: got %b want 000101", {sticky, eff_sub, inc_req}); end
        // Shift AW-1: top bit lands on bit 0, lowest bit goes to sticky
        driveItem(3'b000, 6'b000000, 12'd161, 12'h002, 53'h10_0000_0000_0001, m);
        @(posedge clk); #1;
        exp = '0; exp[0] = 1'b1;
        checks++; if (c_aligned !== exp) begin errors++; $display("[TB] FAIL fp64_d161 c_aligned: got %h want %h", c_aligned, exp); end
        checks++; if (sticky !== 2'b01) begin errors++; $display("[TB] FAIL fp64_d161 sticky: got %b want 01", sticky); end
        // Shift 200: window empty
        driveItem(3'b000, 6'b000000, 12'd200, 12'h003, 53'h10_0000_0000_0001, m);
        @(posedge clk); #1;
        checks++; if (c_aligned !== '0) begin errors++; $display("[TB] FAIL fp64_d200 c_aligned: got %h want 0", c_aligned); end
        checks++; if ({sticky, inc_req} !== 4'b01_00) begin errors++; $display("[TB] FAIL fp64_d200 sticky/inc: got %b want 0100", {sticky, inc_req}); end
        // Shift exactly AW with subtract: inverted empty window, sticky suppresses increment
        driveItem(3'b000, 6'b000010, 12'd162, 12'h004, 53'h00_0000_0000_0001, m);
        @(posedge clk); #1;
        exp = '1;
        checks++; if (c_aligned !== exp) begin errors++; $display("[TB] FAIL fp64_d162 c_aligned: got %h want %h", c_aligned, exp); end
        checks++; if ({sticky, eff_sub, inc_req} !== 6'b01_01_00) begin errors++; $display("[TB] FAIL fp64_d162 flags: got %b want 010100", {sticky, eff_sub, inc_req}); end
        in_valid = 1'b0;
    endtask

    task automatic test_dual();
        logic [AW-1:0] exp;
        // lane1 shift 5 unmodified, lane0 shift 63 inverted; junk in mant_c[52:48]
        driveItem(3'b001, 6'b000001, {6'd5, 6'd63}, 12'h010, {5'h1F, 24'h800001, 24'hFFFFFF}, '0);
        @(posedge clk); #1;
        exp = '0; exp[156] = 1'b1; exp[133] = 1'b1; exp[80:18] = '1;
        checks++; if (c_aligned !== exp) begin errors++; $display("[TB] FAIL dual1 c_aligned: got %h want %h", c_aligned, exp); end
        checks++; if ({sticky, eff_sub, inc_req} !== 6'b01_01_00) begin errors++; $display("[TB] FAIL dual1 flags: got %b want 010100", {sticky, eff_sub, inc_req}); end
        checks++; if (cont_T3 !== 3'b001 || mode_err !== 1'b0) begin errors++; $display("[TB] FAIL dual1 mode: cont_T3 %b mode_err %b want 001/0", cont_T3, mode_err); end
        // lane1 subtract with zero shift, lane0 bit fully shifted out
        driveItem(3'b001, 6'b100000, {6'd0, 6'd58}, 12'h011, {5'h00, 24'hFFFFFF, 24'h000001}, '0);
        @(posedge clk); #1;
        exp = '0; exp[137:81] = '1;
        checks++; if (c_aligned !== exp) begin errors++; $display("[TB] FAIL dual2 c_aligned: got %h want %h", c_aligned, exp); end
        checks++; if ({sticky, eff_sub, inc_req} !== 6'b01_10_10) begin errors++; $display("[TB] FAIL dual2 flags: got %b want 011010", {sticky, eff_sub, inc_req}); end
        in_valid = 1'b0;
    endtask

    task automatic test_single();
        logic [AW-1:0] exp;
        // Shift 80: top bit lands on lane0 bit 0; lane1 inputs ignored
        driveItem(3'b010, 6'b111000, 12'd80, 12'h020, {5'h1F, 24'hABCDEF, 24'hC00000}, '0);
        @(posedge clk); #1;
        exp = '0; exp[0] = 1'b1;
        checks++; if (c_aligned !== exp) begin errors++; $display("[TB] FAIL single_d80 c_aligned: got %h want %h", c_aligned, exp); end
        checks++; if ({sticky, eff_sub, inc_req} !== 6'b01_00_00) begin errors++; $display("[TB] FAIL single_d80 flags: got %b want 010000", {sticky, eff_sub, inc_req}); end
        // Shift 81 saturates; subtract inverts lane0 only
        driveItem(3'b010, 6'b111100, 12'd81, 12'h021, {5'h1F, 24'hABCDEF, 24'hC00000}, '0);
        @(posedge clk); #1;
        exp = '0; exp[80:0] = '1;
        checks++; if (c_aligned !== exp) begin errors++; $display("[TB] FAIL single_d81 c_aligned: got %h want %h", c_aligned, exp); end
        checks++; if ({sticky, eff_sub, inc_req} !== 6'b01_01_00) begin errors++; $display("[TB] FAIL single_d81 flags: got %b want 010100", {sticky, eff_sub, inc_req}); end
        in_valid = 1'b0;
    endtask

    task automatic test_invalid();
        logic [PW-1:0] m;
        m = {18{32'h1234_5678}};
        driveItem(3'b111, 6'b111111, 12'd3, 12'hABC, 53'h1F_FFFF_FFFF_FFFF, m);
        @(posedge clk); #1;
        checks++; if (mode_err !== 1'b1) begin errors++; $display("[TB] FAIL invalid mode_err: got %b want 1", mode_err); end
        checks++; if (c_aligned !== '0 || {sticky, eff_sub, inc_req} !== 6'b0) begin errors++; $display("[TB] FAIL invalid data: c_aligned %h flags %b want 0", c_aligned, {sticky, eff_sub, inc_req}); end
        checks++; if (E_T3 !== 12'hABC || M_out !== m || cont_T3 !== 3'b111) begin errors++; $display("[TB] FAIL invalid passthru: E_T3 %h cont_T3 %b want abc/111", E_T3, cont_T3); end
        driveItem(3'b011, 6'b000000, 12'd0, 12'h055, 53'h1, m);
        @(posedge clk); #1;
        checks++; if (mode_err !== 1'b1 || c_aligned !== '0) begin errors++; $display("[TB] FAIL invalid011: mode_err %b c_aligned %h want 1/0", mode_err, c_aligned); end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        driveItem(3'b000, 6'b000000, 12'd0, 12'h0A1, 53'h1, '0);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp in_ready_c1: got %b want 1", in_ready); end
        @(posedge clk); #1;
        E_T2 = 12'h0A2;
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || E_T3 !== 12'h0A1) begin errors++; $display("[TB] FAIL bp hold%0d: in_ready %b out_valid %b E_T3 %h want 0/1/0a1", i, in_ready, out_valid, E_T3); end
            if (i < 2) begin @(posedge clk); #1; end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp release in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || E_T3 !== 12'h0A2) begin errors++; $display("[TB] FAIL bp second: out_valid %b E_T3 %h want 1/0a2", out_valid, E_T3); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp drain out_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            driveItem(3'b000, 6'b000000, 12'd0, 12'h100 + 12'(i), 53'h1, '0);
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || E_T3 !== 12'h100 + 12'(i)) begin errors++; $display("[TB] FAIL b2b item%0d: out_valid %b E_T3 %h want 1/%h", i, out_valid, E_T3, 12'h100 + 12'(i)); end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || E_T3 !== 12'h103) begin errors++; $display("[TB] FAIL b2b drain: out_valid %b E_T3 %h want 0/103", out_valid, E_T3); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        driveItem(3'b000, 6'b000000, 12'd10, 12'h777, 53'h1F_FFFF_FFFF_FFFF, {18{32'hCAFEF00D}});
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL arst pre out_valid: got %b want 1", out_valid); end
        #2 rstn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst ctrl: out_valid %b in_ready %b want 0/1", out_valid, in_ready); end
        checks++; if (c_aligned !== '0 || M_out !== '0 || E_T3 !== '0) begin errors++; $display("[TB] FAIL arst data: c_aligned %h E_T3 %h want 0", c_aligned, E_T3); end
        #2 rstn = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL arst post: out_valid %b in_ready %b want 0/1", out_valid, in_ready); end
    endtask

    initial begin
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cont_T2   = 3'b000;
        {S_A_T2, S_B_T2, S_C_T2, S_A_H_T2, S_B_H_T2, S_C_H_T2} = 6'b0;
        d_T2      = '0;
        E_T2      = '0;
        mant_c    = '0;
        M_in      = '0;
        #12;
        test_reset();
        #6 rstn = 1'b1;
        @(posedge clk); #1;
        test_fp64();
        test_dual();
        test_single();
        test_invalid();
        @(posedge clk); #1;
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
